// File: rtl/pri_encoder_16.sv
// pri_encoder_16: captures a 16-bit request batch and drains one index per
// valid/ready handshake, lowest-first or highest-first by LSB_FIRST.
module pri_encoder_16 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [3:0]  out_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t      r_state;
  logic [15:0] r_pending;
  logic [3:0]  w_code;
  logic        w_single;
  logic        w_fire;
  // later iterations win, so the final match is the highest-priority bit
  always_comb begin
    w_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (LSB_FIRST ? r_pending[15-i] : r_pending[i]) w_code = LSB_FIRST ? 4'(15 - i) : 4'(i);
    end
  end
  assign w_single  = (r_pending != '0) && ((r_pending & (r_pending - 16'd1)) == '0);
  assign busy      = (r_state == SERVE);
  assign out_valid = busy;
  assign out_code  = busy ? w_code : 4'd0;
  assign out_last  = busy & w_single;
  assign w_fire    = busy & out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else if (r_state == IDLE) begin
      if (en && (req != '0)) begin
        r_pending <= req;
        r_state   <= SERVE;
      end
    end else if (w_fire) begin
      r_pending <= r_pending & ~(16'd1 << w_code);
      if (w_single) r_state <= IDLE;
    end
  end
endmodule
